// File: rtl/mult_pkg.sv
// Shared definitions for the multi-pair multiply sequencer: state codes and default widths.
// ST_WRITE is exported so the top level's RAM write-enable decode matches this FSM.
package mult_pkg;

  localparam int MULT_ADDR_W = 3;
  localparam int MULT_CNT_W  = 3;

  localparam logic [2:0] ST_WRITE = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_LOAD_A = 3'b001,
    S_LOAD_B = 3'b010,
    S_MULT   = 3'b011,
    S_WRITE  = ST_WRITE,
    S_DONE   = 3'b101
  } state_e;

endpackage

// File: rtl/mult_sequencer.sv
// Sequences N operand pairs ROM -> RF -> multiplier -> RAM, 4 cycles per pair plus one DONE cycle.
// All outputs are Moore decodes of state and the src/dst/remaining counters.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int ADDR_W = MULT_ADDR_W,
  parameter int CNT_W  = MULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  pair_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rf_w,
  output logic              rf_da,
  output logic              rf_sa,
  output logic              rf_sb,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [2:0]        st_out
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  rem_q, rem_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    done     = 1'b0;
    rf_w     = 1'b0;
    rf_da    = 1'b0;
    ram_we   = 1'b0;
    rom_addr = '0;
    ram_addr = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (pair_count != '0) begin
            src_d   = src_base;
            dst_d   = dst_base;
            rem_d   = pair_count;
            state_d = S_LOAD_A;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD_A: begin
        rom_addr = src_q;
        rf_w     = 1'b1;
        state_d  = S_LOAD_B;
      end
      S_LOAD_B: begin
        rom_addr = src_q + ADDR_W'(1);
        rf_w     = 1'b1;
        rf_da    = 1'b1;
        state_d  = S_MULT;
      end
      S_MULT: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        ram_we   = 1'b1;
        ram_addr = dst_q;
        src_d    = src_q + ADDR_W'(2);
        dst_d    = dst_q + ADDR_W'(1);
        rem_d    = rem_q - CNT_W'(1);
        state_d  = (rem_q == CNT_W'(1)) ? S_DONE : S_LOAD_A;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      // 110/111 cannot be reached; recover to IDLE if they ever appear.
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign rf_sa  = 1'b0;
  assign rf_sb  = 1'b1;
  assign st_out = state_q;

endmodule
